// File: rtl/onehot_encoder.sv
// onehot_encoder: encodes a one-hot input vector into the index of its lowest
// set bit. Vectors that are all-zero or multi-hot are flagged with out_err.
// Results pass through a 2-entry FIFO with valid/ready handshakes on both
// sides. With FIFO empty, a result appears on the cycle after it is accepted.
// Optional feature: define ONEHOT_ENCODER_ERRCNT_EN to enable err_cnt. It is a
// saturating count of accepted erroneous vectors. When the macro is undefined,
// err_cnt is tied to zero.
module onehot_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    // FIFO entry layout: {err, idx}
    logic [IDX_W:0]   mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_err_q;

    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W:0]   ones;
    logic             enc_err;
    logic [IDX_W:0]   new_entry;
    logic [IDX_W:0]   head_d;
    logic             push;
    logic             pop;

    // Lowest set bit wins; scanning downward leaves the lowest index last.
    // An all-zero vector falls through to index 0.
    always_comb begin
        enc_idx = '0;
        ones    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                enc_idx = IDX_W'(i);
            end
            ones = ones + {{IDX_W{1'b0}}, in_vec[i]};
        end
        enc_err   = (ones != (IDX_W+1)'(1));
        new_entry = {enc_err, enc_idx};
    end

    // Ready is derived from the registered count only.
    // This keeps in_ready free of any path from out_ready.
    assign in_ready = rst_n && (count_q != 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    // Compute the next pointer and occupancy values.
    // Also select the entry that will be at the head after this edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
        // If the new head slot is the one being written this edge, bypass the
        // incoming entry. This covers both an empty FIFO and push-with-pop at
        // count 1.
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = new_entry;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Store the payload; it needs no reset because count gates its use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Update the pointers, count and registered output stage.
    // The output payload holds its last value while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != 2'd0);
            if (count_d != 2'd0) begin
                out_err_q <= head_d[IDX_W];
                out_idx_q <= head_d[IDX_W-1:0];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_err   = out_err_q;

`ifdef ONEHOT_ENCODER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Count accepted erroneous vectors, saturating at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (push && enc_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_onehot_encoder.sv
// Testbench for onehot_encoder (WIDTH = 8) using a queue-based reference model.
// The model and the expected err_cnt literals follow ONEHOT_ENCODER_ERRCNT_EN.
module tb_onehot_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [2:0] idx;
        logic       err;
    } res_t;

    res_t       mq[$];
    logic [2:0] m_last_idx = '0;
    logic       m_last_err = 1'b0;
    int         m_cnt = 0;

    onehot_encoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference encoding: isolate the lowest set bit with two's complement,
    // then take its log2. The error flag comes from the population count.
    function automatic res_t model_encode(input logic [7:0] v);
        res_t       r;
        logic [7:0] lowest;
        lowest = v & (~v + 8'd1);
        r.idx  = (v == 8'd0) ? 3'd0 : 3'($clog2(int'(lowest)));
        r.err  = ($countones(v) != 1);
        return r;
    endfunction

    // Model state update on every rising edge.
    always @(posedge clk) begin
        res_t e;
        if (!rst_n) begin
            mq.delete();
            m_last_idx <= '0;
            m_last_err <= 1'b0;
            m_cnt      <= 0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < 2);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e = model_encode(in_vec);
                mq.push_back(e);
`ifdef ONEHOT_ENCODER_ERRCNT_EN
                if (e.err && m_cnt < 255) m_cnt <= m_cnt + 1;
`endif
            end
            if (mq.size() > 0) begin
                m_last_idx <= mq[0].idx;
                m_last_err <= mq[0].err;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_rdy;
            logic       e_val;
            logic [7:0] e_cnt;
            e_rdy = rst_n && (mq.size() < 2);
            e_val = (mq.size() > 0);
            e_cnt = 8'(m_cnt);
            checks++;
            if (in_ready !== e_rdy || out_valid !== e_val || out_idx !== m_last_idx ||
                out_err !== m_last_err || err_cnt !== e_cnt) begin
                errors++;
                $display("FAIL model t=%0t got rdy=%b val=%b idx=%0d err=%b cnt=%0d want rdy=%b val=%b idx=%0d err=%b cnt=%0d",
                         $time, in_ready, out_valid, out_idx, out_err, err_cnt,
                         e_rdy, e_val, m_last_idx, m_last_err, e_cnt);
            end
        end
    end

    // Apply inputs for the next edge, then return just after the falling edge.
    task automatic step(input logic r, input logic v, input logic [7:0] vec, input logic rdy);
        rst_n     = r;
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rand_vec();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1, 2:    return 8'd1 << $urandom_range(0, 7);
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int exp_cnt;
        step(1'b0, 1'b0, 8'd0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 8'd0, 1'b0);
        lit("reset_out_valid", int'(out_valid), 0);
        lit("reset_in_ready", int'(in_ready), 0);
        lit("reset_out_idx", int'(out_idx), 0);
        step(1'b1, 1'b0, 8'd0, 1'b1);
        lit("ready_after_reset", int'(in_ready), 1);

        // Single accept of a one-hot vector with one-cycle latency.
        step(1'b1, 1'b1, 8'b0010_0000, 1'b1);
        lit("basic_valid", int'(out_valid), 1);
        lit("basic_idx", int'(out_idx), 5);
        lit("basic_err", int'(out_err), 0);
        step(1'b1, 1'b0, 8'd0, 1'b1);
        lit("basic_drain", int'(out_valid), 0);

        // Error vectors: all-zero and multi-hot.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h84, 1'b0);
        lit("zero_idx", int'(out_idx), 0);
        lit("zero_err", int'(out_err), 1);
        step(1'b1, 1'b0, 8'd0, 1'b1);
        lit("multi_idx", int'(out_idx), 2);
        lit("multi_err", int'(out_err), 1);
        step(1'b1, 1'b0, 8'd0, 1'b1);
`ifdef ONEHOT_ENCODER_ERRCNT_EN
        exp_cnt = 2;
`else
        exp_cnt = 0;
`endif
        lit("err_cnt_two", int'(err_cnt), exp_cnt);

        // Backpressure: the third vector waits until space opens.
        step(1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b1, 1'b1, 8'h02, 1'b0);
        lit("full_not_ready", int'(in_ready), 0);
        step(1'b1, 1'b1, 8'h04, 1'b0);
        lit("full_hold_idx", int'(out_idx), 0);
        step(1'b1, 1'b1, 8'h04, 1'b1);
        lit("bp_second_idx", int'(out_idx), 1);
        step(1'b1, 1'b1, 8'h04, 1'b1);
        lit("bp_third_idx", int'(out_idx), 2);
        step(1'b1, 1'b0, 8'd0, 1'b1);
        lit("bp_drain", int'(out_valid), 0);

        // Streaming at count 1: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'd1 << i, 1'b1);
            lit("stream_valid", int'(out_valid), 1);
            lit("stream_idx", int'(out_idx), i);
        end
        step(1'b1, 1'b0, 8'd0, 1'b1);

        // Reset while the FIFO holds two entries.
        step(1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        lit("midrst_valid", int'(out_valid), 0);
        lit("midrst_cnt", int'(err_cnt), 0);
        step(1'b1, 1'b1, 8'h40, 1'b1);
        lit("post_rst_idx", int'(out_idx), 6);
        step(1'b1, 1'b0, 8'd0, 1'b1);

`ifdef ONEHOT_ENCODER_ERRCNT_EN
        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'h00, 1'b1);
        lit("err_cnt_sat", int'(err_cnt), 255);
`endif

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) != 0), 1'($urandom), rand_vec(), 1'($urandom));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_encoder.md
ONEHOT_ENCODER -- requirements
Module: onehot_encoder

Interface
REQ-001 Parameter WIDTH, default 8: input vector width; SHALL be a power of two, 2 to 64.
REQ-002 Parameter IDX_W, default $clog2(WIDTH): index width; SHALL be derived from WIDTH and never overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  in_vec holds a vector to encode.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 in_vec  input  WIDTH  one-hot vector to encode.
REQ-008 out_valid  output  1  out_idx/out_err hold a result.
REQ-009 out_ready  input  1  downstream takes the result this cycle.
REQ-010 out_idx  output  IDX_W  encoded index.
REQ-011 out_err  output  1  source vector was all-zero or multi-hot.
REQ-012 err_cnt  output  8  count of accepted erroneous vectors; see Configuration.

Function
REQ-013 The input accept SHALL occur when in_valid && in_ready are both high on a rising edge; the output pop SHALL occur when out_valid && out_ready are both high.
REQ-014 Results SHALL be held in a 2-entry FIFO; in_ready SHALL equal (rst_n && count != 2), decoded from registered count only.
REQ-015 out_idx SHALL be the position of the lowest set bit of in_vec; an all-zero in_vec SHALL give out_idx = 0.
REQ-016 out_err SHALL be 1 when popcount(in_vec) != 1, otherwise 0.
REQ-017 Latency SHALL be one cycle: a vector accepted at edge t, with the FIFO empty, SHALL appear with out_valid = 1 after edge t.
REQ-018 Results SHALL leave in strict acceptance order; none SHALL be dropped or duplicated.
REQ-019 out_valid, out_idx and out_err SHALL remain stable while out_valid && !out_ready.
REQ-020 With count == 1, a push and a pop on the same edge SHALL leave count at 1 and present the new entry.
REQ-021 With count == 2, in_ready SHALL be 0 and any in_valid SHALL be ignored.
REQ-022 When out_valid = 0, out_idx and out_err SHALL hold their last values.
REQ-023 FIFO read and write pointers SHALL wrap modulo 2.

Reset
REQ-024 While rst_n = 0 at a rising edge, the following SHALL be cleared: count = 0, pointers = 0, out_valid = 0, out_idx = 0, out_err = 0, err_cnt = 0.
REQ-025 A reset asserted mid-operation SHALL discard all buffered results; no pop SHALL be honoured on that edge.
REQ-026 in_ready SHALL be 0 while rst_n = 0, and SHALL go to 1 in the first cycle with rst_n = 1.

Configuration
REQ-027 Macro ONEHOT_ENCODER_ERRCNT_EN defined: err_cnt SHALL increment by 1 on each accepted vector with out_err condition true, saturating at 255.
REQ-028 Macro ONEHOT_ENCODER_ERRCNT_EN undefined: err_cnt SHALL be constant 0 and no counter logic SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-029 Reset then one accept of in_vec = 8'b0010_0000 with out_ready = 1 -> next cycle out_valid = 1, out_idx = 5, out_err = 0; one cycle later out_valid = 0.
REQ-030 Accept 8'b0000_0000 and 8'b1000_0100 -> out_idx = 0, out_err = 1, then out_idx = 2, out_err = 1; err_cnt = 2 with the macro defined, 0 without it.
REQ-031 out_ready = 0, offer 8'h01, 8'h02, 8'h04 -> the first two are accepted and in_ready = 0; release out_ready -> 0, 1 pops in order, then 2 is accepted and pops.
REQ-032 Hold count at 1 with in_valid = out_ready = 1 streaming 8'h01..8'h80 -> one result per cycle with out_idx = 0..7, count stays 1.
REQ-033 Assert rst_n = 0 with 2 entries buffered -> after the edge out_valid = 0, count = 0, err_cnt = 0; after release, the next accept 8'h40 yields out_idx = 6.
REQ-034 Macro defined, 300 accepted all-zero vectors -> err_cnt saturates at 255.
